seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 16 +
 rtl/seg_hex_decoder.sv | 11 +
 rtl/seg_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants for the multiplexed seven-segment scanner
package seg_pkg;

    localparam int BRIGHT_W = 4;

    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high gfedcba patterns for hex digits 0-9, A, b, C, d, E, F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg_hex_decoder.sv
// rtl/seg_hex_decoder.sv - nibble to active-high seven-segment pattern
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0]         nibble,
    output logic [SEG_G:SEG_A] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed display scanner with PWM brightness, blanking and blink
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIG      = 6,
    parameter int SUB_CYC      = 3125,
    parameter int BLINK_FRAMES = 64,
    parameter bit SEL_ACT_LOW  = 1'b1,
    parameter bit SEG_ACT_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*NUM_DIG-1:0]  dis_data,
    input  logic [NUM_DIG-1:0]    dp_in,
    input  logic [NUM_DIG-1:0]    blink_mask,
    input  logic                  lz_blank_en,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [NUM_DIG-1:0]    seg_sel,
    output logic [7:0]            seg_data,
    output logic                  frame_tick
);

    localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int SUB_W = (SUB_CYC > 1) ? $clog2(SUB_CYC) : 1;
    localparam int BF_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [NUM_DIG-1:0] SEL_OFF  = SEL_ACT_LOW ? '1 : '0;
    localparam logic [7:0]         SEG_OFF  = SEG_ACT_LOW ? 8'hFF : 8'h00;

    logic [SUB_W-1:0]      sub_cnt;
    logic [3:0]            phase;
    logic [IDX_W-1:0]      idx;
    logic                  started;
    logic [BF_W-1:0]       blink_cnt;
    logic                  blink_ph;
    logic [4*NUM_DIG-1:0]  cap_data;
    logic [NUM_DIG-1:0]    cap_dp;
    logic [NUM_DIG-1:0]    cap_blink;
    logic                  cap_lz;
    logic [BRIGHT_W-1:0]   bright_q;

    logic                  sub_wrap;
    logic                  slot_start;
    logic                  slot_end;
    logic                  frame_start;
    logic                  blink_toggle;
    logic [4*NUM_DIG-1:0]  eff_data;
    logic [NUM_DIG-1:0]    eff_dp;
    logic [NUM_DIG-1:0]    eff_blink;
    logic                  eff_lz;
    logic [BRIGHT_W-1:0]   eff_bright;
    logic                  eff_blink_ph;
    logic [3:0]            nibble;
    logic [6:0]            hex_seg;
    logic                  dp_cur;
    logic                  blink_cur;
    logic                  lead_zero;
    logic                  blank;
    logic                  lit;
    logic [NUM_DIG-1:0]    sel_act;
    logic [7:0]            seg_act;

    assign sub_wrap    = (sub_cnt == SUB_W'(SUB_CYC - 1));
    assign slot_start  = (sub_cnt == '0) && (phase == 4'd0);
    assign slot_end    = sub_wrap && (phase == 4'd15);
    assign frame_start = slot_start && (idx == '0) && started;
    assign frame_tick  = frame_start;

    // The frame-start cycle itself must already show the freshly captured
    // inputs, so the capture registers are bypassed on that cycle.
    assign blink_toggle = frame_start && (blink_cnt == BF_W'(BLINK_FRAMES - 1));
    assign eff_data     = frame_start ? dis_data    : cap_data;
    assign eff_dp       = frame_start ? dp_in       : cap_dp;
    assign eff_blink    = frame_start ? blink_mask  : cap_blink;
    assign eff_lz       = frame_start ? lz_blank_en : cap_lz;
    assign eff_bright   = slot_start  ? bright      : bright_q;
    assign eff_blink_ph = blink_ph ^ blink_toggle;

    always_comb begin
        nibble    = 4'd0;
        dp_cur    = 1'b0;
        blink_cur = 1'b0;
        lead_zero = 1'b1;
        sel_act   = '0;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (IDX_W'(i) <= idx) begin
                lead_zero = lead_zero && (eff_data[4*(NUM_DIG-1-i) +: 4] == 4'd0);
            end
            if (IDX_W'(i) == idx) begin
                nibble    = eff_data[4*(NUM_DIG-1-i) +: 4];
                dp_cur    = eff_dp[i];
                blink_cur = eff_blink[i];
            end
        end
        blank = eff_lz && lead_zero && (idx != IDX_W'(NUM_DIG - 1));
        lit   = (phase <= eff_bright) && !(eff_blink_ph && blink_cur);
        for (int i = 0; i < NUM_DIG; i++) begin
            sel_act[i] = lit && (IDX_W'(i) == idx);
        end
        seg_act                 = 8'h00;
        seg_act[SEG_DP]         = dp_cur;
        seg_act[SEG_G:SEG_A]    = blank ? 7'h00 : hex_seg;
    end

    seg_hex_decoder u_hex (
        .nibble (nibble),
        .seg    (hex_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sub_cnt   <= '0;
            phase     <= 4'd0;
            idx       <= '0;
            started   <= 1'b0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
            cap_data  <= '0;
            cap_dp    <= '0;
            cap_blink <= '0;
            cap_lz    <= 1'b0;
            bright_q  <= '0;
            seg_sel   <= SEL_OFF;
            seg_data  <= SEG_OFF;
        end else begin
            started <= 1'b1;
            sub_cnt <= sub_wrap ? '0 : sub_cnt + SUB_W'(1);
            if (sub_wrap) begin
                phase <= phase + 4'd1;
            end
            if (slot_end) begin
                idx <= (idx == IDX_W'(NUM_DIG - 1)) ? '0 : idx + IDX_W'(1);
            end
            if (slot_start) begin
                bright_q <= bright;
            end
            if (frame_start) begin
                cap_data  <= dis_data;
                cap_dp    <= dp_in;
                cap_blink <= blink_mask;
                cap_lz    <= lz_blank_en;
                blink_cnt <= blink_toggle ? '0 : blink_cnt + BF_W'(1);
                blink_ph  <= eff_blink_ph;
            end
            seg_sel  <= SEL_ACT_LOW ? ~sel_act : sel_act;
            seg_data <= SEG_ACT_LOW ? ~seg_act : seg_act;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int SC    = 2;
    localparam int BF    = 2;
    localparam int SLOT  = 16 * SC;
    localparam int FRAME = SLOT * ND;

    localparam logic [7:0] HEX_AL [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [15:0]     dis_data = 16'h12AF;
    logic [3:0]      dp_in = 4'h0;
    logic [3:0]      blink_mask = 4'h0;
    logic            lz_blank_en = 1'b0;
    logic [3:0]      bright = 4'd15;
    logic [3:0]      seg_sel;
    logic [7:0]      seg_data;
    logic            frame_tick;

    int errors = 0;
    int checks = 0;

    logic [11:0] sb [$];
    int          t = 0;
    bit          mvalid = 1'b0;
    logic [15:0] m_data;
    logic [3:0]  m_dp, m_blink, m_bright;
    logic        m_lz;

    seg_scan_ctrl #(
        .NUM_DIG      (ND),
        .SUB_CYC      (SC),
        .BLINK_FRAMES (BF),
        .SEL_ACT_LOW  (1'b1),
        .SEG_ACT_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dis_data    (dis_data),
        .dp_in       (dp_in),
        .blink_mask  (blink_mask),
        .lz_blank_en (lz_blank_en),
        .bright      (bright),
        .seg_sel     (seg_sel),
        .seg_data    (seg_data),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d: got %0h expected %0h", tag, t, act, exp);
        end
    endtask

    function automatic logic [11:0] model_out();
        int          idx, ph, nib;
        logic        blank, on, blink_off;
        logic [15:0] head;
        logic [7:0]  d;
        logic [3:0]  s;
        idx       = (t % FRAME) / SLOT;
        ph        = (t % SLOT) / SC;
        head      = m_data >> (4 * (ND - 1 - idx));
        nib       = int'(head[3:0]);
        blank     = m_lz && (idx < ND - 1) && (head == 16'h0);
        blink_off = (((t / FRAME) / BF) % 2) == 1;
        on        = (ph <= int'(m_bright)) && !(blink_off && m_blink[idx]);
        d         = blank ? 8'hFF : HEX_AL[nib];
        d[7]      = ~m_dp[idx];
        s         = on ? ~(4'b0001 << idx) : 4'hF;
        return {s, d};
    endfunction

    // Outputs are checked on the falling edge: the expectation popped here was
    // pushed one cycle earlier from the counter state the DUT has just registered.
    always @(negedge clk) begin
        logic [11:0] e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_val("seg_sel", 32'(seg_sel), 32'(e[11:8]));
            check_val("seg_data", 32'(seg_data), 32'(e[7:0]));
        end
        if (mvalid) begin
            check_val("frame_tick", 32'(frame_tick), 32'((t > 0) && (t % FRAME == 0)));
        end
        if (!rst_n) begin
            sb.push_back({4'hF, 8'hFF});
            t        = 0;
            m_data   = '0;
            m_dp     = '0;
            m_blink  = '0;
            m_lz     = 1'b0;
            m_bright = '0;
            mvalid   = 1'b1;
        end else if (mvalid) begin
            if (t > 0 && t % FRAME == 0) begin
                m_data  = dis_data;
                m_dp    = dp_in;
                m_blink = blink_mask;
                m_lz    = lz_blank_en;
            end
            if (t % SLOT == 0) m_bright = bright;
            sb.push_back(model_out());
            t++;
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        int k;
        k = 0;
        while (frame_tick !== 1'b1 && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        check_val("tick_seen", 32'(frame_tick), 32'h1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        run(3);
        rst_n = 1'b1;
        run(3 * FRAME);

        bright = 4'd3;
        run(2 * FRAME);

        bright      = 4'd15;
        dis_data    = 16'h0005;
        lz_blank_en = 1'b1;
        dp_in       = 4'b0101;
        run(2 * FRAME);
        dis_data = 16'h0000;
        run(2 * FRAME);
        dis_data = 16'h0030;
        run(FRAME);

        lz_blank_en = 1'b0;
        dp_in       = 4'h0;
        wait_tick();
        run(49);
        dis_data = 16'h3C7E;
        run(2 * FRAME);

        run(SLOT / 2 + 5);
        rst_n = 1'b0;
        run(1);
        rst_n      = 1'b1;
        blink_mask = 4'b0010;
        dis_data   = 16'hB8D4;
        run(9 * FRAME);

        bright = 4'd0;
        run(FRAME + 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
